// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline: bus widths, ID->EX field offsets,
// one-hot ALU operation indices and the EX->MEM bus layout.
package pipe_pkg;

    localparam int DS_BUS_W = 137;
    localparam int ES_BUS_W = 72;

    // ID->EX bus field offsets (LSB positions; fields packed MSB first from alu_op down to pc)
    localparam int DS_PC_LSB      = 0;
    localparam int DS_RT_LSB      = 32;
    localparam int DS_RS_LSB      = 64;
    localparam int DS_IMM_LSB     = 96;
    localparam int DS_DEST_LSB    = 112;
    localparam int DS_OV_CHK      = 117;
    localparam int DS_MEM_RE      = 118;
    localparam int DS_MEM_WE      = 119;
    localparam int DS_GR_WE       = 120;
    localparam int DS_SRC2_IS_8   = 121;
    localparam int DS_SRC2_IS_IMM = 122;
    localparam int DS_SRC1_IS_PC  = 123;
    localparam int DS_SRC1_IS_SA  = 124;
    localparam int DS_ALU_OP_LSB  = 125;

    localparam int ALU_OP_W    = 12;
    localparam int ALU_OP_ADD  = 0;
    localparam int ALU_OP_SUB  = 1;
    localparam int ALU_OP_SLT  = 2;
    localparam int ALU_OP_SLTU = 3;
    localparam int ALU_OP_AND  = 4;
    localparam int ALU_OP_NOR  = 5;
    localparam int ALU_OP_OR   = 6;
    localparam int ALU_OP_XOR  = 7;
    localparam int ALU_OP_SLL  = 8;
    localparam int ALU_OP_SRL  = 9;
    localparam int ALU_OP_SRA  = 10;
    localparam int ALU_OP_LUI  = 11;

    typedef struct packed {
        logic        exc_ov;
        logic        mem_re;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_bus_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/alu.sv
// One-hot controlled 32-bit ALU; shifts take the amount from src1 and the value from src2.
// Purely combinational; alu_ov_o flags signed overflow of ADD/SUB only.
module alu
    import pipe_pkg::*;
(
    input  logic [ALU_OP_W-1:0] alu_op_i,
    input  logic [31:0]         alu_src1_i,
    input  logic [31:0]         alu_src2_i,
    output logic [31:0]         alu_result_o,
    output logic                alu_ov_o
);

    logic        is_sub;
    logic [31:0] b_op;
    logic [32:0] sum;
    logic        add_ov;
    logic        slt_res;
    logic        sltu_res;
    logic [4:0]  shamt;

    // SUB, SLT and SLTU share the adder in subtract mode
    assign is_sub   = alu_op_i[ALU_OP_SUB] | alu_op_i[ALU_OP_SLT] | alu_op_i[ALU_OP_SLTU];
    assign b_op     = is_sub ? ~alu_src2_i : alu_src2_i;
    assign sum      = {1'b0, alu_src1_i} + {1'b0, b_op} + {32'b0, is_sub};
    assign add_ov   = (alu_src1_i[31] == b_op[31]) & (sum[31] != alu_src1_i[31]);
    assign slt_res  = (alu_src1_i[31] & ~alu_src2_i[31])
                    | (~(alu_src1_i[31] ^ alu_src2_i[31]) & sum[31]);
    assign sltu_res = ~sum[32];
    assign shamt    = alu_src1_i[4:0];

    always_comb begin
        alu_result_o = 32'b0;
        if (alu_op_i[ALU_OP_ADD] | alu_op_i[ALU_OP_SUB]) alu_result_o = alu_result_o | sum[31:0];
        if (alu_op_i[ALU_OP_SLT])  alu_result_o = alu_result_o | {31'b0, slt_res};
        if (alu_op_i[ALU_OP_SLTU]) alu_result_o = alu_result_o | {31'b0, sltu_res};
        if (alu_op_i[ALU_OP_AND])  alu_result_o = alu_result_o | (alu_src1_i & alu_src2_i);
        if (alu_op_i[ALU_OP_NOR])  alu_result_o = alu_result_o | ~(alu_src1_i | alu_src2_i);
        if (alu_op_i[ALU_OP_OR])   alu_result_o = alu_result_o | (alu_src1_i | alu_src2_i);
        if (alu_op_i[ALU_OP_XOR])  alu_result_o = alu_result_o | (alu_src1_i ^ alu_src2_i);
        if (alu_op_i[ALU_OP_SLL])  alu_result_o = alu_result_o | (alu_src2_i << shamt);
        if (alu_op_i[ALU_OP_SRL])  alu_result_o = alu_result_o | (alu_src2_i >> shamt);
        if (alu_op_i[ALU_OP_SRA])  alu_result_o = alu_result_o | 32'($signed(alu_src2_i) >>> shamt);
        if (alu_op_i[ALU_OP_LUI])  alu_result_o = alu_result_o | {alu_src2_i[15:0], 16'b0};
    end

    assign alu_ov_o = (alu_op_i[ALU_OP_ADD] | alu_op_i[ALU_OP_SUB]) & add_ov;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ID->EX register, operand select, data-SRAM request, EX->MEM bus, bypass tuple.
// Latency 1 cycle (+ addr_ok wait for memory ops); stalls via es_allowin. EXE_OV_TRAP_EN enables overflow traps.
module exe_stage
    import pipe_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic                flush,
    input  logic                ds_to_es_valid,
    input  logic [DS_BUS_W-1:0] ds_to_es_bus,
    output logic                es_allowin,
    input  logic                ms_allowin,
    output logic                es_to_ms_valid,
    output logic [ES_BUS_W-1:0] es_to_ms_bus,
    output logic                data_req,
    output logic                data_wr,
    output logic [3:0]          data_wstrb,
    output logic [31:0]         data_addr,
    output logic [31:0]         data_wdata,
    input  logic                data_addr_ok,
    output logic                es_fwd_valid,
    output logic [4:0]          es_fwd_dest,
    output logic [31:0]         es_fwd_data,
    output logic                es_fwd_is_load
);

    logic                es_valid_q, es_valid_d;
    logic                req_done_q, req_done_d;
    logic [DS_BUS_W-1:0] ds_bus_q, ds_bus_d;

    logic [ALU_OP_W-1:0] alu_op;
    logic        src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8;
    logic        gr_we, mem_we, mem_re, ov_chk;
    logic [4:0]  dest;
    logic [15:0] imm;
    logic [31:0] rs_value, rt_value, pc;

    logic [31:0] alu_src1, alu_src2, alu_result;
    logic        alu_ov;
    logic        ov_trap, gr_we_eff, mem_op, es_ready_go, accept;
    es_bus_t     es_bus;

    assign alu_op      = ds_bus_q[DS_ALU_OP_LSB +: ALU_OP_W];
    assign src1_is_sa  = ds_bus_q[DS_SRC1_IS_SA];
    assign src1_is_pc  = ds_bus_q[DS_SRC1_IS_PC];
    assign src2_is_imm = ds_bus_q[DS_SRC2_IS_IMM];
    assign src2_is_8   = ds_bus_q[DS_SRC2_IS_8];
    assign gr_we       = ds_bus_q[DS_GR_WE];
    assign mem_we      = ds_bus_q[DS_MEM_WE];
    assign mem_re      = ds_bus_q[DS_MEM_RE];
    assign ov_chk      = ds_bus_q[DS_OV_CHK];
    assign dest        = ds_bus_q[DS_DEST_LSB +: 5];
    assign imm         = ds_bus_q[DS_IMM_LSB +: 16];
    assign rs_value    = ds_bus_q[DS_RS_LSB +: 32];
    assign rt_value    = ds_bus_q[DS_RT_LSB +: 32];
    assign pc          = ds_bus_q[DS_PC_LSB +: 32];

    assign alu_src1 = src1_is_sa  ? {27'b0, imm[10:6]} :
                      src1_is_pc  ? pc : rs_value;
    assign alu_src2 = src2_is_imm ? sext16(imm) :
                      src2_is_8   ? 32'd8 : rt_value;

    alu u_alu (
        .alu_op_i     (alu_op),
        .alu_src1_i   (alu_src1),
        .alu_src2_i   (alu_src2),
        .alu_result_o (alu_result),
        .alu_ov_o     (alu_ov)
    );

`ifdef EXE_OV_TRAP_EN
    assign ov_trap = es_valid_q & ov_chk & alu_ov;
`else
    // Without trapping, add/addi behave exactly like addu/addiu
    logic unused_ov;
    assign unused_ov = ov_chk ^ alu_ov;
    assign ov_trap   = 1'b0;
`endif

    assign gr_we_eff   = gr_we & ~ov_trap;
    assign mem_op      = mem_re | mem_we;
    assign es_ready_go = ~mem_op | ov_trap | req_done_q | data_addr_ok;
    assign es_allowin  = ~es_valid_q | (es_ready_go & ms_allowin);
    assign accept      = es_allowin & ds_to_es_valid;

    // Request stays asserted with a stable address until addr_ok; never re-issued afterwards
    assign data_req   = es_valid_q & mem_op & ~req_done_q & ~ov_trap & ~flush;
    assign data_wr    = mem_we;
    assign data_wstrb = mem_we ? 4'hf : 4'h0;
    assign data_addr  = alu_result;
    assign data_wdata = rt_value;

    assign es_to_ms_valid = es_valid_q & es_ready_go & ~flush;
    assign es_bus.exc_ov  = ov_trap;
    assign es_bus.mem_re  = mem_re;
    assign es_bus.gr_we   = gr_we_eff;
    assign es_bus.dest    = dest;
    assign es_bus.result  = alu_result;
    assign es_bus.pc      = pc;
    assign es_to_ms_bus   = es_bus;

    assign es_fwd_valid   = es_valid_q & gr_we_eff & (dest != 5'd0);
    assign es_fwd_dest    = dest;
    assign es_fwd_data    = alu_result;
    assign es_fwd_is_load = mem_re;

    always_comb begin
        es_valid_d = es_valid_q;
        req_done_d = req_done_q;
        ds_bus_d   = ds_bus_q;
        if (es_allowin) es_valid_d = ds_to_es_valid;
        if (accept) ds_bus_d = ds_to_es_bus;
        if (accept) begin
            req_done_d = 1'b0;
        end else if (data_req & data_addr_ok & ~ms_allowin) begin
            req_done_d = 1'b1;
        end
        if (flush) begin
            es_valid_d = 1'b0;
            req_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_q <= 1'b0;
            req_done_q <= 1'b0;
            ds_bus_q   <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            req_done_q <= req_done_d;
            ds_bus_q   <= ds_bus_d;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// Bench for exe_stage; follows EXE_OV_TRAP_EN to choose the expected overflow behaviour.
module tb_exe_stage;

`ifdef EXE_OV_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn, flush, ds_to_es_valid, ms_allowin, data_addr_ok;
    logic [136:0] ds_to_es_bus;
    logic         es_allowin, es_to_ms_valid, data_req, data_wr;
    logic [71:0]  es_to_ms_bus;
    logic [3:0]   data_wstrb;
    logic [31:0]  data_addr, data_wdata, es_fwd_data;
    logic         es_fwd_valid, es_fwd_is_load;
    logic [4:0]   es_fwd_dest;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exe_stage dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .ds_to_es_valid(ds_to_es_valid), .ds_to_es_bus(ds_to_es_bus),
        .es_allowin(es_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .es_fwd_valid(es_fwd_valid), .es_fwd_dest(es_fwd_dest),
        .es_fwd_data(es_fwd_data), .es_fwd_is_load(es_fwd_is_load)
    );

    // Instruction builder in the documented MSB-first field order
    function automatic logic [136:0] mk(input int op, input logic sa1, input logic pc1,
                                        input logic imm2, input logic is8, input logic gwe,
                                        input logic mwe, input logic mre, input logic ovc,
                                        input logic [4:0] dst, input logic [15:0] imm,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [31:0] pc);
        logic [11:0] oh;
        oh = 12'b1 << op;
        return {oh, sa1, pc1, imm2, is8, gwe, mwe, mre, ovc, dst, imm, rs, rt, pc};
    endfunction

    function automatic logic [31:0] ref_result(input int op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << a[4:0];
            9:  return b >> a[4:0];
            10: return 32'($signed(b) >>> a[4:0]);
            default: return b * 32'd65536;
        endcase
    endfunction

    function automatic bit ref_ov(input int op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op == 0) r = sa + sb;
        else if (op == 1) r = sa - sb;
        else return 1'b0;
        return (r > 64'sd2147483647) || (r < -64'sd2147483648);
    endfunction

    task automatic test_reset;
        resetn = 1'b0; flush = 1'b0; ds_to_es_valid = 1'b0; ds_to_es_bus = '0;
        ms_allowin = 1'b1; data_addr_ok = 1'b0;
        #12;
        n_cmp++;
        if (es_allowin !== 1'b1) begin n_bad++; $display("FAIL reset_allowin got %b want 1", es_allowin); end
        n_cmp++;
        if ({es_to_ms_valid, data_req, es_fwd_valid} !== 3'b000)
            begin n_bad++; $display("FAIL reset_outs got %b want 000", {es_to_ms_valid, data_req, es_fwd_valid}); end
        n_cmp++;
        if (es_to_ms_bus !== 72'h0) begin n_bad++; $display("FAIL reset_bus got %h want 0", es_to_ms_bus); end
        @(negedge clk); resetn = 1'b1;
    endtask

    task automatic test_random_alu;
        int op; logic sa1, pc1, imm2, is8, gwe, ovc;
        logic [4:0] dst; logic [15:0] imm; logic [31:0] rs, rt, pc, s1, s2, res;
        bit trap; logic [71:0] exp_bus;
        ms_allowin = 1'b1; data_addr_ok = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 40; i++) begin
            op = $urandom_range(0, 11);
            sa1 = 1'($urandom_range(0, 1)); pc1 = 1'($urandom_range(0, 1));
            imm2 = 1'($urandom_range(0, 1)); is8 = 1'($urandom_range(0, 1));
            gwe = 1'($urandom_range(0, 1)); ovc = 1'($urandom_range(0, 1));
            dst = 5'($urandom); imm = 16'($urandom); rs = $urandom; rt = $urandom; pc = $urandom;
            if ($urandom_range(0, 3) == 0) rs = 32'h7fffffff;
            ds_to_es_valid = 1'b1;
            ds_to_es_bus = mk(op, sa1, pc1, imm2, is8, gwe, 1'b0, 1'b0, ovc, dst, imm, rs, rt, pc);
            s1 = sa1 ? {27'b0, imm[10:6]} : (pc1 ? pc : rs);
            s2 = imm2 ? {{16{imm[15]}}, imm} : (is8 ? 32'd8 : rt);
            res = ref_result(op, s1, s2);
            trap = TRAP_EN && ovc && ref_ov(op, s1, s2);
            exp_bus = {trap, 1'b0, gwe & !trap, dst, res, pc};
            @(posedge clk); #1;
            n_cmp++;
            if ({es_to_ms_valid, es_allowin, data_req} !== 3'b110)
                begin n_bad++; $display("FAIL rnd_hs[%0d] got %b want 110", i, {es_to_ms_valid, es_allowin, data_req}); end
            n_cmp++;
            if (es_to_ms_bus !== exp_bus)
                begin n_bad++; $display("FAIL rnd_bus[%0d] op=%0d got %h want %h", i, op, es_to_ms_bus, exp_bus); end
            n_cmp++;
            if ({es_fwd_valid, es_fwd_dest, es_fwd_data} !== {gwe && !trap && dst != 5'd0, dst, res})
                begin n_bad++; $display("FAIL rnd_fwd[%0d] got %b/%0d/%h want %b/%0d/%h", i,
                    es_fwd_valid, es_fwd_dest, es_fwd_data, gwe && !trap && dst != 5'd0, dst, res); end
        end
        ds_to_es_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (es_to_ms_valid !== 1'b0) begin n_bad++; $display("FAIL rnd_drain got %b want 0", es_to_ms_valid); end
    endtask

    task automatic test_overflow;
        ms_allowin = 1'b1; data_addr_ok = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 5'd3, 16'h0, 32'h7fffffff, 32'h1, 32'hbfc00100);
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        n_cmp++;
        if ({es_to_ms_valid, data_req} !== 2'b10)
            begin n_bad++; $display("FAIL ov_hs got %b want 10", {es_to_ms_valid, data_req}); end
        n_cmp++;
        if ({es_to_ms_bus[71], es_to_ms_bus[69], es_to_ms_bus[63:32]} !== {TRAP_EN, !TRAP_EN, 32'h80000000})
            begin n_bad++; $display("FAIL ov_bus got exc=%b we=%b res=%h want exc=%b we=%b res=80000000",
                es_to_ms_bus[71], es_to_ms_bus[69], es_to_ms_bus[63:32], TRAP_EN, !TRAP_EN); end
        // Overflowing address computation on a load
        @(posedge clk); #1;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(0, 0, 0, 1, 0, 1, 0, 1, 1, 5'd4, 16'h0001, 32'h7fffffff, 32'h0, 32'hbfc00104);
        data_addr_ok = 1'b1;
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        n_cmp++;
        if ({es_to_ms_valid, data_req, es_to_ms_bus[71]} !== {1'b1, !TRAP_EN, TRAP_EN})
            begin n_bad++; $display("FAIL ov_load got v/req/exc=%b want %b", {es_to_ms_valid, data_req, es_to_ms_bus[71]},
                {1'b1, !TRAP_EN, TRAP_EN}); end
        @(posedge clk); #1; data_addr_ok = 1'b0;
    endtask

    task automatic test_load_wait;
        ms_allowin = 1'b1; data_addr_ok = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 5'd8, 16'hfffc, 32'h1000, 32'h0, 32'hbfc00200);
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin data_addr_ok = 1'b1; #1; end
            n_cmp++;
            if ({data_req, data_wr, data_wstrb, data_addr} !== {1'b1, 1'b0, 4'h0, 32'h00000ffc})
                begin n_bad++; $display("FAIL lw_req[%0d] got req=%b wr=%b strb=%h addr=%h want 1/0/0/00000ffc",
                    c, data_req, data_wr, data_wstrb, data_addr); end
            n_cmp++;
            if ({es_allowin, es_to_ms_valid, es_fwd_is_load} !== {c == 3, c == 3, 1'b1})
                begin n_bad++; $display("FAIL lw_hs[%0d] got %b want %b", c,
                    {es_allowin, es_to_ms_valid, es_fwd_is_load}, {c == 3, c == 3, 1'b1}); end
            @(posedge clk); #1;
        end
        data_addr_ok = 1'b0;
        n_cmp++;
        if ({es_to_ms_valid, data_req} !== 2'b00)
            begin n_bad++; $display("FAIL lw_done got %b want 00", {es_to_ms_valid, data_req}); end
    endtask

    task automatic test_store_held;
        logic [31:0] rs, rt; logic [15:0] imm; int hs;
        rs = $urandom & 32'hfffffffc; rt = $urandom; imm = 16'($urandom) & 16'h00fc; hs = 0;
        ms_allowin = 1'b0; data_addr_ok = 1'b1;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 5'd0, imm, rs, rt, 32'hbfc00300);
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 2) begin ms_allowin = 1'b1; #1; end
            if (data_req && data_addr_ok) hs++;
            if (c == 0) begin
                n_cmp++;
                if ({data_req, data_wr, data_wstrb, data_wdata, data_addr} !== {1'b1, 1'b1, 4'hf, rt, rs + {16'h0, imm}})
                    begin n_bad++; $display("FAIL sw_req got req=%b wr=%b strb=%h wd=%h a=%h want 1/1/f/%h/%h",
                        data_req, data_wr, data_wstrb, data_wdata, data_addr, rt, rs + {16'h0, imm}); end
            end
            n_cmp++;
            if ({es_to_ms_valid, es_allowin} !== {c < 3, c >= 2})
                begin n_bad++; $display("FAIL sw_hold[%0d] got %b want %b", c,
                    {es_to_ms_valid, es_allowin}, {c < 3, c >= 2}); end
            @(posedge clk); #1;
        end
        data_addr_ok = 1'b0;
        n_cmp++;
        if (hs != 1) begin n_bad++; $display("FAIL sw_handshakes got %0d want 1", hs); end
    endtask

    task automatic test_sll_fwd;
        ms_allowin = 1'b1; data_addr_ok = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(8, 1, 0, 0, 0, 1, 0, 0, 0, 5'd7, 16'h0100, 32'h12345678, 32'h0000000f, 32'hbfc00400);
        @(posedge clk); #1;
        ds_to_es_bus = mk(8, 1, 0, 0, 0, 1, 0, 0, 0, 5'd0, 16'h0100, 32'h0, 32'h0000000f, 32'hbfc00404);
        n_cmp++;
        if ({es_to_ms_bus[63:32], es_fwd_valid, es_fwd_dest, es_fwd_is_load} !== {32'h000000f0, 1'b1, 5'd7, 1'b0})
            begin n_bad++; $display("FAIL sll_fwd got res=%h v=%b d=%0d ld=%b want 000000f0/1/7/0",
                es_to_ms_bus[63:32], es_fwd_valid, es_fwd_dest, es_fwd_is_load); end
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        n_cmp++;
        if ({es_to_ms_valid, es_fwd_valid} !== 2'b10)
            begin n_bad++; $display("FAIL sll_dest0 got %b want 10", {es_to_ms_valid, es_fwd_valid}); end
    endtask

    task automatic test_flush;
        ms_allowin = 1'b1; data_addr_ok = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 5'd9, 16'h0010, 32'h2000, 32'h0, 32'hbfc00500);
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        flush = 1'b1; #1;
        n_cmp++;
        if ({data_req, es_to_ms_valid} !== 2'b00)
            begin n_bad++; $display("FAIL flush_req got %b want 00", {data_req, es_to_ms_valid}); end
        @(posedge clk); #1; flush = 1'b0;
        n_cmp++;
        if ({es_to_ms_valid, data_req, es_fwd_valid, es_allowin} !== 4'b0001)
            begin n_bad++; $display("FAIL flush_empty got %b want 0001",
                {es_to_ms_valid, data_req, es_fwd_valid, es_allowin}); end
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 5'd9, 16'h0020, 32'h2000, 32'h0, 32'hbfc00504);
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        n_cmp++;
        if ({data_req, data_addr} !== {1'b1, 32'h00002020})
            begin n_bad++; $display("FAIL flush_next got req=%b a=%h want 1/00002020", data_req, data_addr); end
        data_addr_ok = 1'b1;
        @(posedge clk); #1; data_addr_ok = 1'b0;
    endtask

    task automatic test_async_reset;
        ms_allowin = 1'b1; data_addr_ok = 1'b0;
        ds_to_es_valid = 1'b1;
        ds_to_es_bus = mk(0, 0, 0, 1, 0, 1, 0, 1, 0, 5'd10, 16'h0004, 32'h3000, 32'h0, 32'hbfc00600);
        @(posedge clk); #1; ds_to_es_valid = 1'b0;
        n_cmp++;
        if (data_req !== 1'b1) begin n_bad++; $display("FAIL arst_pre got %b want 1", data_req); end
        #2; resetn = 1'b0; #1;
        n_cmp++;
        if ({data_req, es_to_ms_valid, es_fwd_valid, es_allowin} !== 4'b0001)
            begin n_bad++; $display("FAIL arst_now got %b want 0001",
                {data_req, es_to_ms_valid, es_fwd_valid, es_allowin}); end
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({es_allowin, data_req, es_to_ms_valid} !== 3'b100)
            begin n_bad++; $display("FAIL arst_after got %b want 100", {es_allowin, data_req, es_to_ms_valid}); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_random_alu();
        test_overflow();
        test_load_wait();
        test_store_held();
        test_sll_fwd();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
